// File: rtl/sequenciador_exibicao.sv
// Playback controller: walks the jogada memory from address 0 up to the latched
// round index, lighting each jogada for T_ON cycles followed by a T_OFF dark gap.
//
// state   | meaning
// OCIOSO  | idle, waiting for iniciar
// CARREGA | one cycle for the memory read to settle
// ACENDE  | jogada lit on leds for T_ON cycles
// APAGA   | dark gap of T_OFF cycles
// PROXIMO | advance to the next address
// FIM     | one-cycle pronto, hand control back
module sequenciador_exibicao #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4,
   parameter int T_ON   = 50000000,
   parameter int T_OFF  = 25000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              abortar,
   input  logic [ADDR_W-1:0] rodada,
   input  logic [DATA_W-1:0] mem_dado,
   output logic [ADDR_W-1:0] endereco,
   output logic [DATA_W-1:0] leds,
   output logic              ocupado,
   output logic              pronto,
   output logic [3:0]        db_estado
);

   localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [TW-1:0] ON_FIM  = TW'(T_ON - 1);
   localparam logic [TW-1:0] OFF_FIM = TW'(T_OFF - 1);

   typedef enum logic [3:0] {
      OCIOSO  = 4'h0,
      CARREGA = 4'h1,
      ACENDE  = 4'h2,
      APAGA   = 4'h3,
      PROXIMO = 4'h4,
      FIM     = 4'hF
   } estado_t;

   estado_t           estado, estado_prox;
   logic [TW-1:0]     timer, timer_prox;
   logic [ADDR_W-1:0] rodada_reg, rodada_prox;
   logic [ADDR_W-1:0] endereco_prox;
   logic [DATA_W-1:0] leds_prox;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado     <= OCIOSO;
         timer      <= '0;
         rodada_reg <= '0;
         endereco   <= '0;
         leds       <= '0;
      end else begin
         estado     <= estado_prox;
         timer      <= timer_prox;
         rodada_reg <= rodada_prox;
         endereco   <= endereco_prox;
         leds       <= leds_prox;
      end
   end

   always_comb begin
      estado_prox   = estado;
      timer_prox    = timer;
      rodada_prox   = rodada_reg;
      endereco_prox = endereco;
      leds_prox     = leds;
      if (abortar) begin
         estado_prox   = OCIOSO;
         timer_prox    = '0;
         endereco_prox = '0;
         leds_prox     = '0;
      end else begin
         case (estado)
            OCIOSO: begin
               leds_prox = '0;
               if (iniciar) begin
                  estado_prox   = CARREGA;
                  endereco_prox = '0;
                  rodada_prox   = rodada;
                  timer_prox    = '0;
               end
            end
            CARREGA: begin
               leds_prox   = mem_dado;
               timer_prox  = '0;
               estado_prox = ACENDE;
            end
            ACENDE: begin
               if (timer == ON_FIM) begin
                  leds_prox   = '0;
                  timer_prox  = '0;
                  estado_prox = APAGA;
               end else begin
                  timer_prox = timer + 1'b1;
               end
            end
            APAGA: begin
               leds_prox = '0;
               // Last-address test precedes the increment, so endereco never wraps.
               if (timer == OFF_FIM) begin
                  timer_prox  = '0;
                  estado_prox = (endereco == rodada_reg) ? FIM : PROXIMO;
               end else begin
                  timer_prox = timer + 1'b1;
               end
            end
            PROXIMO: begin
               endereco_prox = endereco + 1'b1;
               estado_prox   = CARREGA;
            end
            FIM: begin
               endereco_prox = '0;
               estado_prox   = OCIOSO;
            end
            default: begin
               estado_prox   = OCIOSO;
               timer_prox    = '0;
               endereco_prox = '0;
               leds_prox     = '0;
            end
         endcase
      end
   end

   assign ocupado   = (estado != OCIOSO);
   assign pronto    = (estado == FIM);
   assign db_estado = estado;

endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Bench for sequenciador_exibicao with short timings; expected jogadas are queued
// per playback and matched against each observed lit run of the leds.
module tb_sequenciador_exibicao;

   localparam int T_ON  = 4;
   localparam int T_OFF = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       iniciar, abortar;
   logic [3:0] rodada;
   logic [3:0] mem_dado;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       ocupado, pronto;
   logic [3:0] db_estado;

   logic [3:0] mem [16];

   typedef struct {
      logic [3:0] v;
      logic [3:0] a;
   } jog_t;

   jog_t exp_q[$];
   jog_t e_mon;
   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   bit   mon_en   = 1'b0;

   logic [3:0] prev_leds = 4'h0;
   logic [3:0] run_addr  = 4'h0;
   int         run_len   = 0;

   sequenciador_exibicao #(
      .ADDR_W(4), .DATA_W(4), .T_ON(T_ON), .T_OFF(T_OFF)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .iniciar   (iniciar),
      .abortar   (abortar),
      .rodada    (rodada),
      .mem_dado  (mem_dado),
      .endereco  (endereco),
      .leds      (leds),
      .ocupado   (ocupado),
      .pronto    (pronto),
      .db_estado (db_estado)
   );

   always #5 clock = ~clock;

   assign mem_dado = mem[endereco];

   // Each completed lit run must match the next queued jogada and last exactly T_ON cycles.
   always @(negedge clock) begin
      if (!mon_en) begin
         prev_leds = 4'h0;
         run_len   = 0;
      end else begin
         if (prev_leds !== 4'h0 && leds !== prev_leds) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL jogada_inesperada: got leds=%b addr=%0d len=%0d, expected none", prev_leds, run_addr, run_len);
            end else begin
               e_mon = exp_q.pop_front();
               if (prev_leds !== e_mon.v || run_addr !== e_mon.a || run_len != T_ON)
                  $display("FAIL jogada: got leds=%b addr=%0d len=%0d, expected leds=%b addr=%0d len=%0d",
                           prev_leds, run_addr, run_len, e_mon.v, e_mon.a, T_ON);
               else
                  pass_cnt++;
            end
         end
         if (leds !== 4'h0) begin
            if (leds !== prev_leds) begin
               run_len  = 1;
               run_addr = endereco;
            end else begin
               run_len++;
            end
         end
         prev_leds = leds;
      end
   end

   // Starts a playback from a negedge and measures it; returns at a negedge.
   task automatic play(input logic [3:0] r, input int abort_at, input int reinit_at, input int chg_at,
                       output int cyc_pronto, output int n_pronto, output int n_ocup,
                       output int max_end, output bit wrapped);
      int prev_end;
      cyc_pronto = -1; n_pronto = 0; n_ocup = 0; max_end = 0; wrapped = 1'b0; prev_end = 0;
      rodada  = r;
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      for (int n = 1; n <= 3000; n++) begin
         if (pronto === 1'b1) begin
            n_pronto++;
            if (cyc_pronto < 0) cyc_pronto = n;
         end
         if (ocupado === 1'b1) begin
            n_ocup++;
            if (int'(endereco) < prev_end) wrapped = 1'b1;
            if (int'(endereco) > max_end) max_end = int'(endereco);
            prev_end = int'(endereco);
         end
         if (n == chg_at) rodada = 4'h0;
         iniciar = (n == reinit_at || n == abort_at);
         abortar = (n == abort_at);
         if (abort_at > 0 && n == abort_at + 1) break;
         if (cyc_pronto > 0 && n >= cyc_pronto + 3) break;
         @(negedge clock);
      end
      iniciar = 1'b0;
      abortar = 1'b0;
   endtask

   task automatic load_onehot();
      for (int i = 0; i < 16; i++) mem[i] = 4'h0;
      mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
   endtask

   task automatic test_reset();
      reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; rodada = 4'h0;
      load_onehot();
      repeat (2) @(negedge clock);
      chk_cnt++;
      if (leds !== 4'h0 || endereco !== 4'h0) $display("FAIL reset_dados: got leds=%b end=%0d, expected 0 0", leds, endereco);
      else pass_cnt++;
      chk_cnt++;
      if (ocupado !== 1'b0 || pronto !== 1'b0 || db_estado !== 4'h0)
         $display("FAIL reset_ctrl: got ocupado=%b pronto=%b db=%h, expected 0 0 0", ocupado, pronto, db_estado);
      else pass_cnt++;
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset_mid();
      mon_en  = 1'b0;
      rodada  = 4'h1;
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      repeat (9) @(negedge clock);
      chk_cnt++;
      if (leds !== 4'b0010 || endereco !== 4'h1 || db_estado !== 4'h2)
         $display("FAIL pre_reset: got leds=%b end=%0d db=%h, expected 0010 1 2", leds, endereco, db_estado);
      else pass_cnt++;
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk_cnt++;
      if (leds !== 4'h0 || ocupado !== 1'b0 || endereco !== 4'h0 || db_estado !== 4'h0)
         $display("FAIL reset_async: got leds=%b ocupado=%b end=%0d db=%h, expected 0 0 0 0", leds, ocupado, endereco, db_estado);
      else pass_cnt++;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      mon_en = 1'b1;
   endtask

   task automatic test_rodada_zero();
      int cp, np, no, me; bit wr;
      exp_q.push_back('{v: 4'b0001, a: 4'h0});
      play(4'h0, 0, 0, 0, cp, np, no, me, wr);
      chk_cnt++;
      if (cp != 8 || np != 1) $display("FAIL r0_pronto: got cycle=%0d count=%0d, expected 8 1", cp, np);
      else pass_cnt++;
      chk_cnt++;
      if (me != 0 || no != 8) $display("FAIL r0_end: got max_end=%0d ocup=%0d, expected 0 8", me, no);
      else pass_cnt++;
      chk_cnt++;
      if (exp_q.size() != 0) $display("FAIL r0_fila: got %0d pending, expected 0", exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_rodada_tres();
      int cp, np, no, me; bit wr;
      for (int i = 0; i < 4; i++) exp_q.push_back('{v: mem[i], a: 4'(i)});
      play(4'h3, 0, 0, 0, cp, np, no, me, wr);
      chk_cnt++;
      if (cp != 32 || np != 1) $display("FAIL r3_pronto: got cycle=%0d count=%0d, expected 32 1", cp, np);
      else pass_cnt++;
      chk_cnt++;
      if (no != 32 || me != 3) $display("FAIL r3_ocup: got ocup=%0d max_end=%0d, expected 32 3", no, me);
      else pass_cnt++;
      chk_cnt++;
      if (exp_q.size() != 0) $display("FAIL r3_fila: got %0d pending, expected 0", exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int cp, np, no, me; bit wr;
      for (int i = 0; i < 3; i++) exp_q.push_back('{v: mem[i], a: 4'(i)});
      play(4'h2, 0, 10, 3, cp, np, no, me, wr);
      chk_cnt++;
      if (cp != 24 || np != 1) $display("FAIL latch_pronto: got cycle=%0d count=%0d, expected 24 1", cp, np);
      else pass_cnt++;
      chk_cnt++;
      if (me != 2 || exp_q.size() != 0) $display("FAIL latch_jogadas: got max_end=%0d pending=%0d, expected 2 0", me, exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_abortar();
      int cp, np, no, me, extra; bit wr;
      exp_q.push_back('{v: mem[0], a: 4'h0});
      exp_q.push_back('{v: mem[1], a: 4'h1});
      play(4'h3, 14, 0, 0, cp, np, no, me, wr);
      chk_cnt++;
      if (leds !== 4'h0 || ocupado !== 1'b0 || endereco !== 4'h0 || db_estado !== 4'h0 || pronto !== 1'b0)
         $display("FAIL abort_estado: got leds=%b ocupado=%b end=%0d db=%h pronto=%b, expected 0 0 0 0 0",
                  leds, ocupado, endereco, db_estado, pronto);
      else pass_cnt++;
      extra = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clock);
         if (pronto === 1'b1 || ocupado === 1'b1) extra++;
      end
      chk_cnt++;
      if (np != 0 || extra != 0) $display("FAIL abort_sem_pronto: got pronto_before=%0d active_after=%0d, expected 0 0", np, extra);
      else pass_cnt++;
      chk_cnt++;
      if (exp_q.size() != 0) $display("FAIL abort_fila: got %0d pending, expected 0", exp_q.size());
      else pass_cnt++;
      exp_q.push_back('{v: mem[0], a: 4'h0});
      play(4'h0, 0, 0, 0, cp, np, no, me, wr);
      chk_cnt++;
      if (cp != 8 || np != 1 || me != 0 || exp_q.size() != 0)
         $display("FAIL abort_reinicio: got cycle=%0d count=%0d max_end=%0d pending=%0d, expected 8 1 0 0", cp, np, me, exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_todos_enderecos();
      int cp, np, no, me; bit wr;
      for (int i = 0; i < 16; i++) begin
         mem[i] = 4'(i) ^ 4'h7;
         if (mem[i] != 4'h0) exp_q.push_back('{v: mem[i], a: 4'(i)});
      end
      play(4'hF, 0, 0, 0, cp, np, no, me, wr);
      chk_cnt++;
      if (cp != 128 || np != 1) $display("FAIL r15_pronto: got cycle=%0d count=%0d, expected 128 1", cp, np);
      else pass_cnt++;
      chk_cnt++;
      if (me != 15 || wr != 1'b0) $display("FAIL r15_endereco: got max_end=%0d wrapped=%0b, expected 15 0", me, wr);
      else pass_cnt++;
      chk_cnt++;
      if (exp_q.size() != 0) $display("FAIL r15_fila: got %0d pending, expected 0", exp_q.size());
      else pass_cnt++;
      chk_cnt++;
      if (endereco !== 4'h0 || ocupado !== 1'b0) $display("FAIL r15_fim: got end=%0d ocupado=%b, expected 0 0", endereco, ocupado);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_rodada_zero();
      test_rodada_tres();
      test_back_to_back();
      test_abortar();
      test_todos_enderecos();
      repeat (2) @(negedge clock);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/sequenciador_exibicao.md
Name: sequenciador_exibicao

Overview:
Playback controller for the memory-game datapath. On request, it walks the jogada memory from address 0 up to the current round index. Each stored jogada is shown on the LEDs for a fixed on-time, followed by a dark gap. It drives the memory address and LED lines itself and hands control back to the main control unit with a one-cycle done pulse.

Parameters:
ADDR_W, 4, width of memory address and round index
DATA_W, 4, width of stored jogada / LED bus (one-hot)
T_ON, 50000000, clock cycles each jogada is lit (>=1)
T_OFF, 25000000, clock cycles of dark gap after each jogada (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
iniciar  input  1  start playback; sampled in OCIOSO only
abortar  input  1  synchronous abort; forces OCIOSO next edge from any state
rodada  input  ADDR_W  last address to display; latched when start accepted
mem_dado  input  DATA_W  jogada read from memory; valid 1 cycle after endereco changes
endereco  output  ADDR_W  memory read address (registered)
leds  output  DATA_W  LED drive (registered)
ocupado  output  1  high in every state except OCIOSO
pronto  output  1  one-cycle pulse on completion
db_estado  output  4  debug state code

Behaviour:
- Reset: asynchronous, active-high, with `reset` on `clock`.
- Reset values: state=OCIOSO, endereco=0, leds=0, ocupado=0, pronto=0, timer=0, rodada_reg=0, db_estado=0.
- States and db_estado codes: OCIOSO(0), CARREGA(1), ACENDE(2), APAGA(3), PROXIMO(4), FIM(F).
- OCIOSO:
  - iniciar=1 -> CARREGA; endereco<=0, rodada_reg<=rodada, timer<=0.
  - Otherwise stay.
  - leds=0.
- CARREGA: exactly 1 cycle, absorbing memory read latency. On exit, leds<=mem_dado, timer<=0 -> ACENDE.
- ACENDE:
  - leds hold the latched value; timer increments each cycle.
  - When timer==T_ON-1: leds<=0, timer<=0 -> APAGA.
  - leds are lit for exactly T_ON cycles.
- APAGA:
  - leds=0; timer increments.
  - When timer==T_OFF-1: -> FIM if endereco==rodada_reg, else -> PROXIMO.
- PROXIMO: endereco<=endereco+1 -> CARREGA (1 cycle).
- FIM: pronto=1 for this single cycle; endereco<=0 -> OCIOSO.
- Per-jogada period:
  - First jogada: 1(CARREGA)+T_ON+T_OFF.
  - Subsequent jogadas: add 1 cycle for PROXIMO.
  - Total start-to-pronto for R=rodada_reg: (R+1)*(1+T_ON+T_OFF) + R + 1 cycles, counting from the edge that accepts iniciar to the pronto cycle inclusive.
- iniciar while ocupado=1: ignored; does not restart.
- rodada changing mid-playback: no effect (latched copy used).
- rodada=0: exactly one jogada shown.
- rodada=2^ADDR_W-1: all addresses shown. endereco never wraps past rodada_reg, because comparison happens before increment.
- abortar=1 in any state:
  - Next edge: OCIOSO, leds=0, endereco=0, timer=0, pronto=0.
  - abortar has priority over iniciar and over all timer transitions.
- abortar in OCIOSO: stays OCIOSO. iniciar is ignored that cycle.
- mem_dado is not checked for one-hot; it is displayed as-is.
- Timer width: ceil(log2(max(T_ON,T_OFF))) bits, no overflow allowed.
- Unreachable state encodings -> OCIOSO.
- Outputs are Moore/registered; no combinational path from any input to leds or pronto.

Test Plan:
1. Reset mid-ACENDE (reset pulse asynchronous to clock) -> leds=0, ocupado=0, endereco=0 immediately, db_estado=0.
2. T_ON=4, T_OFF=2, memory {0001,0010,0100,1000}, rodada=0, iniciar pulse -> leds=0001 for exactly 4 cycles, 2 dark cycles, pronto pulse on cycle 8 after accept; endereco stays 0.
3. Same params, rodada=3 -> leds sequence 0001,0010,0100,1000, each 4 cycles, each followed by 2 dark cycles; endereco 0..3; pronto on cycle 4*7+3+1=32; ocupado high cycles 1..32.
4. rodada=2 at start, rodada driven to 0 during ACENDE, iniciar re-pulsed mid-playback -> still shows 3 jogadas, single pronto, no restart.
5. abortar asserted during second APAGA with iniciar also high -> next cycle OCIOSO, leds=0, no pronto; a later iniciar restarts from endereco 0.
6. rodada=15, all addresses loaded distinct -> 16 jogadas displayed in order, endereco reaches 15 and does not wrap to 0 before FIM.
